vmem_arbiter: RTL and testbench

//  Owns the single port of extended video RAM. Shares it between the hires fetch

---
 rtl/vmem_arbiter_if.sv | 45 ++++
 rtl/vmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_vmem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/vmem_arbiter_if.sv
// vmem_arbiter_if: hires, CPU and block-RAM signals shared by the video RAM arbiter and its clients.
// The block engine signals exist only when VMEM_BLOCK_OP_EN is defined.
interface vmem_arbiter_if #(
  parameter int ram_width = 16
);
  logic                 hires_active;
  logic [ram_width-1:0] hires_addr;
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ram_width-1:0] cpu_addr;
  logic [7:0]           cpu_wdata;
  logic                 cpu_ack;
  logic [7:0]           cpu_rdata;
  logic [ram_width-1:0] ram_addr;
  logic                 ram_we;
  logic [7:0]           ram_wdata;
  logic [7:0]           ram_rdata;
`ifdef VMEM_BLOCK_OP_EN
  logic                 blk_start;
  logic                 blk_fill;
  logic [ram_width-1:0] blk_src;
  logic [ram_width-1:0] blk_dst;
  logic [15:0]          blk_len;
  logic [7:0]           blk_val;
  logic                 blk_busy;
`endif

  modport slave (
    input  hires_active, hires_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
`ifdef VMEM_BLOCK_OP_EN
    input  blk_start, blk_fill, blk_src, blk_dst, blk_len, blk_val,
    output blk_busy,
`endif
    output cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output hires_active, hires_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
`ifdef VMEM_BLOCK_OP_EN
    output blk_start, blk_fill, blk_src, blk_dst, blk_len, blk_val,
    input  blk_busy,
`endif
    input  cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: owns the single video RAM port; hires fetch > CPU > block engine.
// Define VMEM_BLOCK_OP_EN to build in the block copy/fill engine.
module vmem_arbiter #(
  parameter int ram_width = 16
) (
  input logic           clk_dot4x,
  input logic           rst,
  vmem_arbiter_if.slave bus
);

`ifdef VMEM_BLOCK_OP_EN
  typedef enum logic [2:0] {IDLE, RD1, RD2, WRACK, BRD, BW1, BW2, BWR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD1, RD2, WRACK} state_t;
`endif

  state_t               state;
  state_t               next_state;
  logic                 ack_r;
  logic                 ack_next;
  logic [7:0]           rdata_r;
  logic [ram_width-1:0] addr_mux;
  logic                 we_mux;
  logic [7:0]           wdata_mux;
`ifdef VMEM_BLOCK_OP_EN
  logic                 busy_r;
  logic                 fill_r;
  logic [ram_width-1:0] src_r;
  logic [ram_width-1:0] dst_r;
  logic [15:0]          len_r;
  logic [7:0]           byte_r;
  logic                 byte_done;
`endif

  // Arbitration, next state and the combinational RAM port mux
  always_comb begin
    next_state = state;
    ack_next   = 1'b0;
    addr_mux   = bus.hires_addr;
    we_mux     = 1'b0;
    wdata_mux  = 8'h00;
`ifdef VMEM_BLOCK_OP_EN
    byte_done  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.hires_active) begin
          next_state = IDLE;
        end else if (bus.cpu_req) begin
          addr_mux = bus.cpu_addr;
          if (bus.cpu_we) begin
            we_mux     = 1'b1;
            wdata_mux  = bus.cpu_wdata;
            ack_next   = 1'b1;
            next_state = WRACK;
          end else begin
            next_state = RD1;
          end
        end
`ifdef VMEM_BLOCK_OP_EN
        else if (busy_r && (len_r != 16'd0)) begin
          next_state = fill_r ? BWR : BRD;
        end
`endif
        else begin
          next_state = IDLE;
        end
      end
      // The RAM already holds the read address, so a rising hires window cannot stop it
      RD1: begin
        next_state = RD2;
        ack_next   = 1'b1;
      end
      RD2:   next_state = IDLE;
      WRACK: next_state = IDLE;
`ifdef VMEM_BLOCK_OP_EN
      BRD: begin
        if (bus.hires_active) begin
          next_state = BRD;
        end else begin
          addr_mux   = src_r;
          next_state = BW1;
        end
      end
      BW1: next_state = BW2;
      BW2: next_state = BWR;
      BWR: begin
        if (bus.hires_active) begin
          next_state = BWR;
        end else begin
          addr_mux   = dst_r;
          we_mux     = 1'b1;
          wdata_mux  = fill_r ? bus.blk_val : byte_r;
          byte_done  = 1'b1;
          next_state = IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // FSM state, completion pulse and read data holding register
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      state   <= IDLE;
      ack_r   <= 1'b0;
      rdata_r <= 8'h00;
    end else begin
      state <= next_state;
      ack_r <= ack_next;
      if (state == RD2) begin
        rdata_r <= bus.ram_rdata;
      end
    end
  end

`ifdef VMEM_BLOCK_OP_EN
  // Block engine: operand latch, per-byte address/length advance and completion
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      busy_r <= 1'b0;
      fill_r <= 1'b0;
      src_r  <= '0;
      dst_r  <= '0;
      len_r  <= 16'd0;
      byte_r <= 8'h00;
    end else begin
      if (bus.blk_start && !busy_r) begin
        busy_r <= 1'b1;
        fill_r <= bus.blk_fill;
        src_r  <= bus.blk_src;
        dst_r  <= bus.blk_dst;
        len_r  <= bus.blk_len;
      end else if (busy_r && (len_r == 16'd0)) begin
        busy_r <= 1'b0;
      end else if (byte_done) begin
        dst_r <= dst_r + ram_width'(1);
        if (!fill_r) begin
          src_r <= src_r + ram_width'(1);
        end
        len_r <= len_r - 16'd1;
        if (len_r == 16'd1) begin
          busy_r <= 1'b0;
        end
      end
      if (state == BW2) begin
        byte_r <= bus.ram_rdata;
      end
    end
  end

  assign bus.blk_busy = busy_r;
`endif

  assign bus.ram_addr  = addr_mux;
  assign bus.ram_we    = we_mux;
  assign bus.ram_wdata = wdata_mux;
  assign bus.cpu_ack   = ack_r;
  // Read data is forwarded straight from the RAM in RD2 so it lines up with the ack
  assign bus.cpu_rdata = (state == RD2) ? bus.ram_rdata : rdata_r;

endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter: randomized scoreboard bench; a shadow byte memory predicts every CPU read.
// Block copy/fill scenarios run only when VMEM_BLOCK_OP_EN is defined.
module tb_vmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vmem_arbiter_if bus ();
  vmem_arbiter dut (.clk_dot4x(clk), .rst(rst), .bus(bus));

  logic [7:0] mem [0:65535];
  logic [7:0] rd_p1;
  logic [7:0] ref_mem [int];
  logic [8:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
`ifdef VMEM_BLOCK_OP_EN
  int   blk_wr_count = 0;
  int   blk_last_wr = -10;
  int   busy_fall = -1;
  logic busy_prev = 1'b0;
`endif

  // Video block RAM: read data appears two cycles after the address
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    rd_p1         <= mem[bus.ram_addr];
    bus.ram_rdata <= rd_p1;
    cyc_cnt       <= cyc_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: scoreboard pops on every ack, and hires cycles must never write
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.hires_active) begin
        chk("hires_no_we", bus.ram_we, 1'b0);
        chk("hires_addr", bus.ram_addr, bus.hires_addr);
      end
      if (bus.cpu_ack) begin
        chk("ack_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          if (exp_q[0][8]) chk("read_data", bus.cpu_rdata, exp_q[0][7:0]);
          void'(exp_q.pop_front());
        end
      end
`ifdef VMEM_BLOCK_OP_EN
      if (bus.ram_we && !(bus.cpu_req && bus.cpu_we && bus.ram_addr == bus.cpu_addr)) begin
        blk_wr_count <= blk_wr_count + 1;
        blk_last_wr  <= cyc_cnt;
      end
      if (busy_prev && !bus.blk_busy) busy_fall <= cyc_cnt;
      busy_prev <= bus.blk_busy;
`endif
    end
  end

  // One CPU transaction; hires owns the port for pre_hires cycles, and for post_hires
  // cycles right after the grant. strict = exact grant cycle and latency are known.
  task automatic cpu_xfer(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                          input int pre_hires, input int post_hires, input bit strict);
    bit acked = 1'b0;
    int lat = we ? 1 : 2;
    if (we) begin
      ref_mem[addr] = wd;
      exp_q.push_back({1'b0, 8'h00});
    end else begin
      exp_q.push_back({1'b1, ref_mem[addr]});
    end
    for (int c = 0; c < pre_hires + 60 && !acked; c++) begin
      @(posedge clk); #1;
      bus.cpu_req      = 1'b1;
      bus.cpu_we       = we;
      bus.cpu_addr     = addr;
      bus.cpu_wdata    = wd;
      bus.hires_active = (c < pre_hires) || (c > pre_hires && c <= pre_hires + post_hires);
      bus.hires_addr   = 16'($urandom);
      @(negedge clk);
      if (strict && c == pre_hires) begin
        chk("grant_addr", bus.ram_addr, addr);
        chk("grant_we", bus.ram_we, we);
        if (we) chk("grant_wdata", bus.ram_wdata, wd);
      end
      if (bus.cpu_ack) begin
        acked = 1'b1;
        if (strict) chk("ack_latency", c, pre_hires + lat);
      end
    end
    if (!acked) chk("ack_timeout", acked, 1'b1);
    @(posedge clk); #1;
    bus.cpu_req      = 1'b0;
    bus.hires_active = 1'b0;
  endtask

`ifdef VMEM_BLOCK_OP_EN
  task automatic blk_go(input bit fill, input logic [15:0] src, input logic [15:0] dst,
                        input logic [15:0] len, input logic [7:0] val);
    @(posedge clk); #1;
    bus.blk_start = 1'b1;
    bus.blk_fill  = fill;
    bus.blk_src   = src;
    bus.blk_dst   = dst;
    bus.blk_len   = len;
    bus.blk_val   = val;
    @(posedge clk); #1;
    bus.blk_start = 1'b0;
  endtask

  task automatic blk_wait(input int base, input int n_wr, input string tag);
    for (int c = 0; c < 300 && bus.blk_busy; c++) begin
      @(posedge clk); #1;
      bus.hires_active = ($urandom_range(0, 2) == 0);
      bus.hires_addr   = 16'($urandom);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.hires_active = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, bus.blk_busy, 1'b0);
    chk({tag, "_writes"}, blk_wr_count - base, n_wr);
    chk({tag, "_busy_fall"}, busy_fall, blk_last_wr + 1);
  endtask
`endif

  initial begin
    logic [15:0] ra;
    bit          acked;
    rst = 1'b1;
    bus.hires_active = 1'b0; bus.hires_addr = 16'h0000;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
`ifdef VMEM_BLOCK_OP_EN
    bus.blk_start = 1'b0; bus.blk_fill = 1'b0; bus.blk_src = 16'h0000;
    bus.blk_dst = 16'h0000; bus.blk_len = 16'd0; bus.blk_val = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ack", bus.cpu_ack, 1'b0);
    chk("reset_rdata", bus.cpu_rdata, 8'h00);
    chk("reset_we", bus.ram_we, 1'b0);
    chk("reset_wdata", bus.ram_wdata, 8'h00);
`ifdef VMEM_BLOCK_OP_EN
    chk("reset_busy", bus.blk_busy, 1'b0);
`endif

    // Directed: write then read back, read overlapped by hires, long hires blocking
    cpu_xfer(1'b1, 16'h1234, 8'h5A, 0, 0, 1'b1);
    cpu_xfer(1'b0, 16'h1234, 8'h00, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) cpu_xfer(1'b1, 16'h1230 + 16'(i), 8'($urandom), 0, 0, 1'b1);
    cpu_xfer(1'b0, 16'h1235, 8'h00, 0, 2, 1'b1);
    cpu_xfer(1'b1, 16'h1236, 8'hC3, 10, 0, 1'b1);
    cpu_xfer(1'b0, 16'h1236, 8'h00, 10, 0, 1'b1);

    // Reset lands in RD1: the read is dropped, then the held request is served again
    ra = 16'h1233;
    exp_q.push_back({1'b1, ref_mem[ra]});
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = ra;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rd1_ack", bus.cpu_ack, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_ack", bus.cpu_ack, 1'b0);
    chk("rst_after_rdata", bus.cpu_rdata, 8'h00);
    chk("rst_after_we", bus.ram_we, 1'b0);
    chk("rst_regrant_addr", bus.ram_addr, ra);
    acked = 1'b0;
    for (int c = 3; c < 12 && !acked; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.cpu_ack) begin
        acked = 1'b1;
        chk("rst_regrant_latency", c, 4);
      end
    end
    if (!acked) chk("rst_regrant_timeout", acked, 1'b1);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;

    // Randomized traffic over a small address window so reads hit earlier writes
    for (int n = 0; n < 40; n++) begin
      ra = 16'h1230 + 16'($urandom_range(0, 7));
      cpu_xfer(1'($urandom_range(0, 1)), ra, 8'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
    end

`ifdef VMEM_BLOCK_OP_EN
    begin
      int base;
      int nbusy;
      for (int i = 0; i < 4; i++) cpu_xfer(1'b1, 16'h0100 + 16'(i), 8'($urandom), 0, 0, 1'b1);
      for (int i = 0; i < 4; i++) ref_mem[16'h0200 + i] = ref_mem[16'h0100 + i];
      base = blk_wr_count;
      blk_go(1'b0, 16'h0100, 16'h0200, 16'd4, 8'h00);
      @(negedge clk);
      chk("copy_busy_start", bus.blk_busy, 1'b1);
      cpu_xfer(1'b1, 16'h3000, 8'h77, 1, 0, 1'b0);
      blk_wait(base, 4, "copy");
      for (int i = 0; i < 4; i++) cpu_xfer(1'b0, 16'h0200 + 16'(i), 8'h00, 0, 0, 1'b1);
      cpu_xfer(1'b0, 16'h3000, 8'h00, 0, 0, 1'b1);

      base = blk_wr_count;
      ref_mem[16'hFFFF] = 8'hAA; ref_mem[16'h0000] = 8'hAA; ref_mem[16'h0001] = 8'hAA;
      blk_go(1'b1, 16'h0000, 16'hFFFF, 16'd3, 8'hAA);
      blk_wait(base, 3, "fill");
      cpu_xfer(1'b0, 16'hFFFF, 8'h00, 0, 0, 1'b1);
      cpu_xfer(1'b0, 16'h0000, 8'h00, 0, 0, 1'b1);
      cpu_xfer(1'b0, 16'h0001, 8'h00, 0, 0, 1'b1);

      base = blk_wr_count;
      nbusy = 0;
      blk_go(1'b1, 16'h0000, 16'h0040, 16'd0, 8'h55);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus.blk_busy) nbusy++;
        @(posedge clk); #1;
      end
      chk("len0_busy_cycles", nbusy, 1);
      chk("len0_writes", blk_wr_count - base, 0);
    end
`endif

    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
